ava_dma: RTL and testbench

AVA_DMA -- requirements
Module: ava_dma

---
 rtl/wishbone_p_if.sv | 24 ++
 rtl/ava_dma.sv | 219 +++++++++++++++++++++
 tb/tb_ava_dma.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_p_if.sv
// Pipelined Wishbone bus bundle shared by a single master and a single slave.
//   cyc, stb, we, adr[31:0], sel[3:0], dat_o[31:0] : driven by the master
//   dat_i[31:0], ack, stall                        : driven by the slave
interface wishbone_p_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack;
   logic        stall;

   modport master (
      output cyc, stb, we, adr, sel, dat_o,
      input  dat_i, ack, stall
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_o,
      output dat_i, ack, stall
   );
endinterface

// File: rtl/ava_dma.sv
// Memory-to-memory copy engine with a pipelined Wishbone master port.
// Copies len_words 32-bit words from src_adr to dst_adr in bursts of up to
// BURST_LEN words: each burst is read into a local buffer, cyc drops for one
// cycle, then the buffer is written out.
//   clk_i      : clock (also the Wishbone clock)
//   rst_i      : asynchronous active-high reset
//   start      : one-cycle copy request (ignored unless idle)
//   abort      : one-cycle cancel of a running copy
//   src_adr    : source byte address, bits [1:0] ignored
//   dst_adr    : destination byte address, bits [1:0] ignored
//   len_words  : number of words to copy
//   busy       : copy in progress
//   done       : one-cycle pulse on successful completion
//   wb         : pipelined Wishbone master
module ava_dma #(
   parameter int unsigned BURST_LEN = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start,
   input  logic         abort,
   input  logic [31:0]  src_adr,
   input  logic [31:0]  dst_adr,
   input  logic [15:0]  len_words,
   output logic         busy,
   output logic         done,
   wishbone_p_if.master wb
);

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StGapRw,
      StWrite,
      StGapWr,
      StDone
   } state_e;

   localparam logic [3:0] BurstMax = 4'(BURST_LEN);

   // Words in the next burst: min(BURST_LEN, remaining).
   function automatic logic [3:0] f_burst(input logic [15:0] rem);
      if (rem < {12'd0, BurstMax}) return rem[3:0];
      return BurstMax;
   endfunction

   state_e      r_state;
   logic [31:0] r_src;
   logic [31:0] r_dst;
   logic [15:0] r_rem;
   logic [3:0]  r_n;
   logic [3:0]  r_issue_cnt;
   logic [3:0]  r_ack_cnt;
   logic        r_cyc;
   logic        r_stb;
   logic        r_we;
   logic [3:0]  r_sel;
   logic [31:0] r_adr;
   logic [31:0] r_dat;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_buf [8];

   logic        w_accept;
   logic        w_ack_ok;
   logic [3:0]  w_issue_nxt;
   logic [3:0]  w_ack_nxt;
   logic [15:0] w_rem_after;

   assign w_accept    = r_stb & ~wb.stall;
   // Acks outside a bus cycle or past the n-th of a burst are dropped.
   assign w_ack_ok    = r_cyc & wb.ack & (r_ack_cnt < r_n);
   assign w_issue_nxt = r_issue_cnt + 4'd1;
   assign w_ack_nxt   = r_ack_cnt + 4'd1;
   assign w_rem_after = r_rem - {12'd0, r_n};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= StIdle;
         r_src       <= '0;
         r_dst       <= '0;
         r_rem       <= '0;
         r_n         <= '0;
         r_issue_cnt <= '0;
         r_ack_cnt   <= '0;
         r_cyc       <= 1'b0;
         r_stb       <= 1'b0;
         r_we        <= 1'b0;
         r_sel       <= '0;
         r_adr       <= '0;
         r_dat       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // busy is high exactly in READ/GAP_RW/WRITE/GAP_WR, so this covers
         // every state in which abort is honoured.
         if (abort && r_busy) begin
            r_state <= StIdle;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               StIdle: begin
                  if (start) begin
                     if (len_words != 16'd0) begin
                        r_state     <= StRead;
                        r_src       <= src_adr & 32'hFFFF_FFFC;
                        r_dst       <= dst_adr & 32'hFFFF_FFFC;
                        r_rem       <= len_words;
                        r_n         <= f_burst(len_words);
                        r_issue_cnt <= '0;
                        r_ack_cnt   <= '0;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_we        <= 1'b0;
                        r_sel       <= 4'hF;
                        r_adr       <= src_adr & 32'hFFFF_FFFC;
                        r_busy      <= 1'b1;
                     end else begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                     end
                  end
               end

               StRead: begin
                  if (w_accept) begin
                     r_issue_cnt <= w_issue_nxt;
                     r_src       <= r_src + 32'd4;
                     r_adr       <= r_src + 32'd4;
                     if (w_issue_nxt == r_n) r_stb <= 1'b0;
                  end
                  if (w_ack_ok) begin
                     r_ack_cnt <= w_ack_nxt;
                     if (w_ack_nxt == r_n) begin
                        r_state <= StGapRw;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                     end
                  end
               end

               StGapRw: begin
                  r_state     <= StWrite;
                  r_issue_cnt <= '0;
                  r_ack_cnt   <= '0;
                  r_cyc       <= 1'b1;
                  r_stb       <= 1'b1;
                  r_we        <= 1'b1;
                  r_adr       <= r_dst;
                  r_dat       <= r_buf[0];
               end

               StWrite: begin
                  if (w_accept) begin
                     r_issue_cnt <= w_issue_nxt;
                     r_dst       <= r_dst + 32'd4;
                     r_adr       <= r_dst + 32'd4;
                     r_dat       <= r_buf[w_issue_nxt[2:0]];
                     if (w_issue_nxt == r_n) r_stb <= 1'b0;
                  end
                  if (w_ack_ok) begin
                     r_ack_cnt <= w_ack_nxt;
                     if (w_ack_nxt == r_n) begin
                        r_rem <= w_rem_after;
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        if (w_rem_after == 16'd0) begin
                           r_state <= StDone;
                           r_done  <= 1'b1;
                           r_busy  <= 1'b0;
                        end else begin
                           r_state <= StGapWr;
                        end
                     end
                  end
               end

               StGapWr: begin
                  r_state     <= StRead;
                  r_n         <= f_burst(r_rem);
                  r_issue_cnt <= '0;
                  r_ack_cnt   <= '0;
                  r_cyc       <= 1'b1;
                  r_stb       <= 1'b1;
                  r_adr       <= r_src;
               end

               StDone: begin
                  r_state <= StIdle;
               end

               default: begin
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

   // Burst buffer; contents are don't-care after reset so it has none.
   always_ff @(posedge clk_i) begin
      if (r_state == StRead && w_ack_ok) r_buf[r_ack_cnt[2:0]] <= wb.dat_i;
   end

   assign wb.cyc   = r_cyc;
   assign wb.stb   = r_stb;
   assign wb.we    = r_we;
   assign wb.adr   = r_adr;
   assign wb.sel   = r_sel;
   assign wb.dat_o = r_dat;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_ava_dma.sv
// Bench for ava_dma: a pipelined Wishbone slave model with optional random
// stall and ack latency, plus a scoreboard of expected bus requests.
module tb_ava_dma;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } txn_t;

   typedef struct packed {
      logic [31:0] dat;
      int unsigned due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [31:0] src_adr;
   logic [31:0] dst_adr;
   logic [15:0] len_words;
   logic        busy;
   logic        done;

   wishbone_p_if wb_if();

   ava_dma #(.BURST_LEN(4)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start     (start),
      .abort     (abort),
      .src_adr   (src_adr),
      .dst_adr   (dst_adr),
      .len_words (len_words),
      .busy      (busy),
      .done      (done),
      .wb        (wb_if)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          wr_accepts = 0;
   int          rd_accepts = 0;
   int unsigned stall_pct = 0;
   int unsigned lat_max = 1;
   txn_t        exp_q[$];
   pend_t       pend[$];

   // Source memory contents: a fixed function of the word address.
   function automatic logic [31:0] pat(input logic [31:0] a);
      return a ^ 32'hA5C3_5A3C;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_cyc"}, 32'(wb_if.cyc), 32'd0);
      chk({nm, "_stb"}, 32'(wb_if.stb), 32'd0);
      chk({nm, "_we"}, 32'(wb_if.we), 32'd0);
      chk({nm, "_adr"}, wb_if.adr, 32'd0);
      chk({nm, "_sel"}, 32'(wb_if.sel), 32'd0);
      chk({nm, "_dat"}, wb_if.dat_o, 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_done"}, 32'(done), 32'd0);
   endtask

   // Expected request order for a copy with BURST_LEN=4.
   task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int unsigned len);
      int unsigned rem = len;
      int unsigned n;
      logic [31:0] sa = s;
      logic [31:0] da = d;
      while (rem > 0) begin
         n = (rem < 4) ? rem : 4;
         for (int i = 0; i < int'(n); i++) exp_q.push_back('{we: 1'b0, adr: sa + 32'(4 * i), dat: 32'd0});
         for (int i = 0; i < int'(n); i++)
            exp_q.push_back('{we: 1'b1, adr: da + 32'(4 * i), dat: pat(sa + 32'(4 * i))});
         sa  = sa + 32'(4 * n);
         da  = da + 32'(4 * n);
         rem = rem - n;
      end
   endtask

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                              input bit with_abort);
      @(negedge clk);
      start     = 1'b1;
      abort     = with_abort;
      src_adr   = s | 32'h2;
      dst_adr   = d | 32'h1;
      len_words = len;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                           input bit with_abort, input string nm);
      int d0 = done_cnt;
      bit got = 1'b0;
      pulse_start(s, d, len, with_abort);
      chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
      end else begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no done pulse within 1000 cycles", nm);
      end
      repeat (3) @(negedge clk);
      #1;
      chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
      chk({nm, "_exp_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Slave model and monitor. Everything happens on the falling edge: ack and
   // stall set here take effect at the next rising edge, and a request seen
   // with stb=1, stall=0 here is the one accepted at that edge.
   initial begin
      int unsigned cyc_no;
      int unsigned due;
      int          gap;
      bit          hold_pend;
      logic        h_we;
      logic [3:0]  h_sel;
      logic [31:0] h_adr;
      logic [31:0] h_dat;
      txn_t        e;
      cyc_no = 0;
      gap = 0;
      hold_pend = 1'b0;
      h_we = 1'b0;
      h_sel = '0;
      h_adr = '0;
      h_dat = '0;
      wb_if.ack = 1'b0;
      wb_if.stall = 1'b0;
      wb_if.dat_i = '0;
      forever begin
         @(negedge clk);
         cyc_no++;
         if (done) done_cnt++;
         chk("stb_without_cyc", 32'(wb_if.stb & ~wb_if.cyc), 32'd0);

         if (busy && !wb_if.cyc) begin
            gap++;
         end else if (busy && gap > 0) begin
            chk("cyc_gap_len", 32'(gap), 32'd1);
            gap = 0;
         end else if (!busy) begin
            gap = 0;
         end

         if (hold_pend && wb_if.cyc && wb_if.stb) begin
            chk("hold_adr", wb_if.adr, h_adr);
            chk("hold_dat", wb_if.dat_o, h_dat);
            chk("hold_we", 32'(wb_if.we), 32'(h_we));
            chk("hold_sel", 32'(wb_if.sel), 32'(h_sel));
         end

         if (!wb_if.cyc) begin
            pend.delete();
            wb_if.ack = 1'b0;
         end else if (pend.size() > 0 && pend[0].due <= cyc_no) begin
            wb_if.ack   = 1'b1;
            wb_if.dat_i = pend[0].dat;
            void'(pend.pop_front());
         end else begin
            wb_if.ack = 1'b0;
         end

         wb_if.stall = wb_if.cyc && wb_if.stb && ($urandom_range(99, 0) < stall_pct);
         hold_pend = wb_if.cyc && wb_if.stb && wb_if.stall;
         h_we  = wb_if.we;
         h_sel = wb_if.sel;
         h_adr = wb_if.adr;
         h_dat = wb_if.dat_o;

         if (wb_if.cyc && wb_if.stb && !wb_if.stall) begin
            due = cyc_no + $urandom_range(lat_max, 1);
            if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
            pend.push_back('{dat: pat(wb_if.adr), due: due});
            if (wb_if.we) wr_accepts++;
            else rd_accepts++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_req: got adr %08h we %0d expected no request",
                        wb_if.adr, wb_if.we);
            end else begin
               e = exp_q.pop_front();
               chk("req_we", 32'(wb_if.we), 32'(e.we));
               chk("req_adr", wb_if.adr, e.adr);
               chk("req_sel", 32'(wb_if.sel), 32'hF);
               if (e.we) chk("req_wdat", wb_if.dat_o, e.dat);
            end
         end
      end
   end

   logic [31:0] t1_adr [12] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                32'h2000, 32'h2004, 32'h2008, 32'h200C,
                                32'h1010, 32'h1014, 32'h2010, 32'h2014};
   logic [31:0] t1_src [12] = '{32'h0, 32'h0, 32'h0, 32'h0,
                                32'h1000, 32'h1004, 32'h1008, 32'h100C,
                                32'h0, 32'h0, 32'h1010, 32'h1014};
   bit          t1_we  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int d0;
      int target;
      bit got;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      src_adr = '0;
      dst_adr = '0;
      len_words = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Zero-stall, one-cycle-ack copy of 6 words.
      for (int i = 0; i < 12; i++)
         exp_q.push_back('{we: t1_we[i], adr: t1_adr[i], dat: t1_we[i] ? pat(t1_src[i]) : 32'h0});
      run_copy(32'h1000, 32'h2000, 16'd6, 1'b0, "len6");

      // Random stall and ack latency.
      stall_pct = 50;
      lat_max = 3;
      push_copy(32'h3000, 32'h8000, 9);
      run_copy(32'h3000, 32'h8000, 16'd9, 1'b0, "len9_stall");
      stall_pct = 0;
      lat_max = 1;

      // Zero-length copy.
      pulse_start(32'h1000, 32'h2000, 16'd0, 1'b0);
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_cyc", 32'(wb_if.cyc), 32'd0);
      @(negedge clk);
      chk("len0_done_after", 32'(done), 32'd0);
      chk("len0_cyc_after", 32'(wb_if.cyc), 32'd0);
      chk("len0_busy_after", 32'(busy), 32'd0);

      // Abort during the second write burst.
      push_copy(32'h4000, 32'h9000, 8);
      d0 = done_cnt;
      target = wr_accepts + 5;
      pulse_start(32'h4000, 32'h9000, 16'd8, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (wr_accepts >= target) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL abort_wait: second write burst not reached in 300 cycles");
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_cyc", 32'(wb_if.cyc), 32'd0);
      chk("abort_stb", 32'(wb_if.stb), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      exp_q.delete();
      push_copy(32'h5000, 32'h6000, 3);
      run_copy(32'h5000, 32'h6000, 16'd3, 1'b0, "after_abort");

      // Source address wrap; abort in the start cycle must lose to start.
      push_copy(32'hFFFF_FFF8, 32'h0000_0100, 4);
      run_copy(32'hFFFF_FFF8, 32'h0000_0100, 16'd4, 1'b1, "wrap");

      // Asynchronous reset in the middle of a read burst.
      push_copy(32'h7000, 32'h7800, 8);
      target = rd_accepts + 2;
      pulse_start(32'h7000, 32'h7800, 16'd8, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (rd_accepts >= target) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL rst_wait: read burst not reached in 100 cycles");
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      exp_q.delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      push_copy(32'h7100, 32'h7900, 5);
      run_copy(32'h7100, 32'h7900, 16'd5, 1'b0, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation did not finish within 500000 time units");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
